// File: rtl/fifo_write_ctrl_if.sv
// Producer-side valid/ready write handshake into the FIFO write controller.
interface fifo_write_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;

  // Producer side: offers words, observes ready.
  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  // Controller side: accepts words, drives ready.
  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/fifo_write_ctrl.sv
// Write-side pointer and handshake controller for the async FIFO.
// Owns the binary/Gray write pointer, drives the memory write port and
// computes the write-side fill level against the synchronized read pointer.
module fifo_write_ctrl #(
  parameter int WIDTH        = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_write_ctrl_if.slave      wr_if,
  input  logic                  full,
  input  logic [WIDTH:0]        rd_ptr,
  output logic [WIDTH:0]        wr_ptr,
  output logic                  mem_we,
  output logic [WIDTH-1:0]      mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [WIDTH:0]        wr_count,
  output logic                  almost_full
);

  localparam logic [WIDTH:0] AFULL_LVL = (WIDTH+1)'(AFULL_THRESH);

  logic [WIDTH:0]        wbin_q, wbin_d;
  logic [WIDTH:0]        wr_ptr_q, wr_ptr_d;
  logic                  mem_we_q, mem_we_d;
  logic [WIDTH-1:0]      mem_waddr_q, mem_waddr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [WIDTH:0]        wr_count_q, wr_count_d;
  logic                  almost_full_q, almost_full_d;

  logic [WIDTH:0]        rbin;
  logic                  full_now;
  logic                  accept;

  // Local full from our own registered pointer; the handler's full lags a cycle.
  assign full_now = (wr_ptr_q == {~rd_ptr[WIDTH:WIDTH-1], rd_ptr[WIDTH-2:0]});

  assign wr_if.wr_ready = ~rst & ~full & ~full_now;
  assign accept         = wr_if.wr_valid & wr_if.wr_ready;

  // Gray-to-binary of the synchronized read pointer: bit i is the XOR of bits >= i.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      rbin[i] = ^(rd_ptr >> i);
    end
  end

  // Next-state: pointer advance, memory port capture and fill level.
  always_comb begin
    wbin_d      = wbin_q;
    wr_ptr_d    = wr_ptr_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    if (accept) begin
      wbin_d      = wbin_q + 1'b1;
      wr_ptr_d    = wbin_d ^ (wbin_d >> 1);
      mem_we_d    = 1'b1;
      mem_waddr_d = wbin_q[WIDTH-1:0];
      mem_wdata_d = wr_if.wr_data;
    end
    // Modulo subtraction keeps the count correct across pointer wrap.
    wr_count_d    = wbin_d - rbin;
    almost_full_d = (wr_count_d >= AFULL_LVL);
  end

  // Register all state; async reset clears outputs immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q        <= '0;
      wr_ptr_q      <= '0;
      mem_we_q      <= 1'b0;
      mem_waddr_q   <= '0;
      mem_wdata_q   <= '0;
      wr_count_q    <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wr_ptr_q      <= wr_ptr_d;
      mem_we_q      <= mem_we_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_wdata_q   <= mem_wdata_d;
      wr_count_q    <= wr_count_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign wr_ptr      = wr_ptr_q;
  assign mem_we      = mem_we_q;
  assign mem_waddr   = mem_waddr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wr_count    = wr_count_q;
  assign almost_full = almost_full_q;

endmodule

// File: doc/fifo_write_ctrl.md
Name: fifo_write_ctrl

Overview:
- Write-side pointer and handshake controller for the async FIFO; sits directly upstream of the write handler.
- Accepts producer writes on a valid/ready handshake and drives the dual-port memory write port.
- Owns the binary and Gray-coded write pointer; the Gray pointer feeds the write handler and the write-to-read synchronizer.
- Consumes the synchronized Gray read pointer and the handler's registered full; produces fill count and almost_full.

Parameters:
- WIDTH, 4, address bits; FIFO depth = 2^WIDTH; pointers are WIDTH+1 bits.
- DATA_WIDTH, 8, data word width.
- AFULL_THRESH, 12, fill level at or above which almost_full asserts (1..2^WIDTH).

Ports:
- clk  input  1  write-domain clock.
- rst  input  1  reset, asynchronous, active-high.
- wr_valid  input  1  producer has a word.
- wr_data  input  DATA_WIDTH  producer word.
- wr_ready  output  1  block can accept; a write is accepted when wr_valid & wr_ready.
- full  input  1  registered full from write handler.
- rd_ptr  input  WIDTH+1  Gray read pointer, already 2FF-synchronized into clk.
- wr_ptr  output  WIDTH+1  Gray write pointer, registered.
- mem_we  output  1  memory write enable.
- mem_waddr  output  WIDTH  memory write address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- wr_count  output  WIDTH+1  fill level seen from write side, 0..2^WIDTH.
- almost_full  output  1  wr_count >= AFULL_THRESH.

Behaviour:
- Reset (async, rst=1): internal binary pointer wbin=0, wr_ptr=0, mem_we=0, mem_waddr=0, mem_wdata=0, wr_count=0, almost_full=0; wr_ready=0 while rst high.
- Local full: full_now = (wr_ptr == {~rd_ptr[WIDTH:WIDTH-1], rd_ptr[WIDTH-2:0]}), combinational on the registered wr_ptr.
  - Required because handler full lags wr_ptr by one cycle.
- wr_ready = ~rst & ~full & ~full_now, combinational; wr_valid may assert independently of wr_ready.
- Accept cycle, at the next clk edge:
  - wbin <= wbin+1, modulo 2^(WIDTH+1).
  - wr_ptr <= (wbin+1) ^ ((wbin+1)>>1).
  - mem_we <= 1; mem_waddr <= wbin[WIDTH-1:0]; mem_wdata <= wr_data.
- Non-accept cycle: mem_we <= 0; pointers, mem_waddr and mem_wdata hold.
- Latency: accepted word reaches the memory port 1 cycle after acceptance; wr_ptr updates on the same edge. Throughput is 1 word/cycle.
- Fill count:
  - rbin = Gray-to-binary(rd_ptr), combinational.
  - wr_count <= (wbin_next - rbin) mod 2^(WIDTH+1) each cycle, where wbin_next is the value wbin takes on this edge.
  - almost_full <= (that same value >= AFULL_THRESH).
  - Both reflect a write on the same edge as wr_ptr; read-side frees are seen with synchronizer latency.
- Wrap-around: wbin 2^(WIDTH+1)-1 -> 0; Gray pointer changes one bit per increment (e.g. 10000 -> 00000 for WIDTH=4). wr_count is correct across wrap via modulo subtraction.
- Full boundary: at wbin = rbin + 2^WIDTH, full_now=1 and wr_ready=0 in that same cycle; no write is ever accepted into a full FIFO.
- Simultaneous: an accept and an rd_ptr advance in the same cycle are both reflected in the next wr_count.
- Reset mid-burst: outputs clear immediately (async), not on the next edge; an in-flight accept is discarded and mem_we falls with rst.

Test Plan:
- Reset: assert rst mid-simulation -> wr_ptr=0, mem_we=0, wr_count=0, almost_full=0, wr_ready=0 before the next clk edge.
- Fill: rd_ptr=00000, wr_valid=1 for 20 cycles, data 0x10+i:
  - exactly 16 accepts; mem_waddr 0..15 with data 0x10..0x1F.
  - Final wr_ptr=11000; wr_ready=0 from the cycle wr_ptr=11000; wr_count=16.
- Almost full: during the fill, almost_full rises on the edge wr_count becomes 12 and never drops while rd_ptr is static.
- Drain release: from full, set rd_ptr=00110 (binary 4) -> wr_ready=1 next cycle; wr_count=12; 4 more writes to addresses 0..3; full again at wr_ptr gray(20)=11110.
- Wrap: reader model tracks writer with 2-cycle lag for 40 writes -> wbin wraps past 31; wr_ptr sequence is valid Gray (single-bit steps); wr_count never exceeds 16; addresses cycle 0..15.
- Backpressure: drive handler full=1 with full_now=0 -> wr_ready=0, mem_we=0, no pointer change.
